dff: RTL and testbench

DFF -- requirements
Module: dff

---
 rtl/dff.sv | 47 ++++
 tb/tb_dff.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dff.sv
// Single-clock D register with optional load enable and an
// asynchronous active-low reset that forces q to RST_VAL.
module dff #(
    parameter bit               USE_EN  = 1'b0,
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             load;

    generate
        if (USE_EN) begin : g_en
            assign load = en;
        end else begin : g_no_en
            // en is intentionally dropped when the enable is not built in
            logic unused_en;
            assign unused_en = en;
            assign load      = 1'b1;
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_dff.sv
// Scoreboard bench for dff: three configurations driven with
// directed vectors, checked at falling edges and on async events.
module tb_dff;

    logic       clk;
    logic       rst;
    logic       d0, en0, q0;
    logic       d1, en1, q1;
    logic [7:0] d2, q2;
    logic       en2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        int         id;
        logic [7:0] exp;
    } sb_t;

    sb_t  sbq[$];
    event chk_ev;

    dff #(.USE_EN(1'b0), .WIDTH(1), .RST_VAL(1'b0)) u0 (
        .clk(clk), .rst(rst), .d(d0), .en(en0), .q(q0)
    );

    dff #(.USE_EN(1'b1), .WIDTH(1), .RST_VAL(1'b0)) u1 (
        .clk(clk), .rst(rst), .d(d1), .en(en1), .q(q1)
    );

    dff #(.USE_EN(1'b1), .WIDTH(8), .RST_VAL(8'hA5)) u2 (
        .clk(clk), .rst(rst), .d(d2), .en(en2), .q(q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push3(input string nm, input logic e0,
                         input logic e1, input logic [7:0] e2);
        sbq.push_back('{{nm, "/u0"}, 0, {7'b0, e0}});
        sbq.push_back('{{nm, "/u1"}, 1, {7'b0, e1}});
        sbq.push_back('{{nm, "/u2"}, 2, e2});
    endtask

    // Drive one vector, push expectations after the edge,
    // and return at the falling edge where they are checked.
    task automatic step(input string nm,
                        input logic a0, input logic b0, input logic e0,
                        input logic a1, input logic b1, input logic e1,
                        input logic [7:0] a2, input logic b2,
                        input logic [7:0] e2);
        d0 = a0; en0 = b0;
        d1 = a1; en1 = b1;
        d2 = a2; en2 = b2;
        @(posedge clk);
        push3(nm, e0, e1, e2);
        @(negedge clk);
    endtask

    always begin
        @(negedge clk or chk_ev);
        while (sbq.size() > 0) begin
            sb_t        e;
            logic [7:0] act;
            e = sbq.pop_front();
            case (e.id)
                0:       act = {7'b0, q0};
                1:       act = {7'b0, q1};
                default: act = q2;
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: q=%h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        d0 = 1'b1; en0 = 1'b1;
        d1 = 1'b1; en1 = 1'b1;
        d2 = 8'hFF; en2 = 1'b1;
        @(posedge clk);
        push3("reset", 1'b0, 1'b0, 8'hA5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        push3("release_no_change", 1'b0, 1'b0, 8'hA5);
        ->chk_ev;
        @(negedge clk);

        step("v1", 0, 0, 0,  1, 1, 1,  8'h3C, 1, 8'h3C);
        step("v2", 1, 1, 1,  0, 0, 1,  8'hFF, 0, 8'h3C);
        step("v3", 1, 0, 1,  0, 1, 0,  8'hFF, 1, 8'hFF);
        step("v4", 0, 1, 0,  1, 1, 1,  8'h00, 1, 8'h00);
        step("v5", 1, 0, 1,  0, 0, 1,  8'h5A, 0, 8'h00);

        // Mid-high-phase async reset with clk static
        d0 = 1; en0 = 1; d1 = 1; en1 = 1; d2 = 8'h77; en2 = 1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        push3("async_assert", 1'b0, 1'b0, 8'hA5);
        ->chk_ev;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            push3("held_reset", 1'b0, 1'b0, 8'hA5);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        push3("release_hold", 1'b0, 1'b0, 8'hA5);
        ->chk_ev;
        @(negedge clk);

        step("post_rel", 1, 1, 1,  1, 1, 1,  8'hC3, 1, 8'hC3);

        // Reset landing on the same edge as a load must win
        d0 = 0; en0 = 1; d1 = 0; en1 = 1; d2 = 8'h11; en2 = 1;
        @(posedge clk);
        rst = 1'b0;
        #1;
        push3("edge_reset", 1'b0, 1'b0, 8'hA5);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        step("final", 1, 0, 1,  1, 0, 0,  8'h96, 1, 8'h96);

        @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d left expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
